mac_array_ctrl: RTL and testbench

Sequencer for one 2-D systolic MAC array core. It reads kernel words and then activation words from a shared input SRAM and drives the array's 2-bit instruction (kernel load, then execute) aligned with the 1-cycle SRAM read data. It also counts completed output vectors from the array's valid flags and signals done. One instance sits per core, between the core's top-level command interface and the array plus its input SRAM.

---
 rtl/core_pkg.sv | 23 ++
 rtl/mac_array_ctrl_step_counter.sv | 28 ++
 rtl/mac_array_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mac_array_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the MAC array sequencer: FSM state encoding,
// array instruction codes and a small width helper.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KLOAD  = 3'd1,
    KFLUSH = 3'd2,
    EXEC   = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_KLOAD = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;

  // Larger of two integers, used when sizing the shared step counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mac_array_ctrl_step_counter.sv
// Loadable down-counter with a terminal-count flag. The sequencer loads
// (duration - 1) on entry to a timed state and leaves when tc is high.
module step_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc
);

  // Load takes priority; otherwise count down and stop at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for one systolic MAC array core: streams kernel words then
// activation words out of the input SRAM, drives the array instruction one
// cycle behind each read, and counts finished output vectors.
module mac_array_ctrl
  import core_pkg::*;
#(
  parameter int row       = 8,
  parameter int col       = 8,
  parameter int addr_bw   = 11,
  parameter int cnt_bw    = 11,
  parameter int flush_cyc = 16,
  parameter int drain_max = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] a_base,
  input  logic [cnt_bw-1:0]  num_act,
  input  logic [col-1:0]     valid,
  output logic               mem_cen,
  output logic               mem_wen,
  output logic [addr_bw-1:0] mem_addr,
  output logic [1:0]         inst_w,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [cnt_bw-1:0]  out_cnt
);

  // Wide enough for any state duration, including a full-range num_act.
  localparam int STEP_W = $clog2(max_int(max_int(max_int(col, flush_cyc),
                                                 max_int(drain_max, row)),
                                         1 << cnt_bw)) + 1;

  state_t               state_reg;
  logic [addr_bw-1:0]   w_base_reg;
  logic [addr_bw-1:0]   a_base_reg;
  logic [cnt_bw-1:0]    num_act_reg;

  logic                 step_load;
  logic                 step_en;
  logic [STEP_W-1:0]    step_load_val;
  logic [STEP_W-1:0]    step_count;
  logic                 step_tc;

  // Only the last column's flag marks a completed output vector.
  logic                 unused_valid;
  assign unused_valid = ^valid[col-2:0];

  // The SRAM is only ever read by this block.
  assign mem_wen = 1'b1;

  step_counter #(.W(STEP_W)) u_step (
    .clk      (clk),
    .reset    (reset),
    .load     (step_load),
    .en       (step_en),
    .load_val (step_load_val),
    .count    (step_count),
    .tc       (step_tc)
  );

  // Step counter control: load the next duration on each timed transition,
  // otherwise count down while inside a timed state.
  always_comb begin
    step_load     = 1'b0;
    step_en       = 1'b0;
    step_load_val = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          step_load     = 1'b1;
          step_load_val = STEP_W'(col - 1);
        end
      end
      KLOAD: begin
        if (step_tc) begin
          step_load     = 1'b1;
          step_load_val = STEP_W'(flush_cyc - 1);
        end else begin
          step_en = 1'b1;
        end
      end
      KFLUSH: begin
        if (step_tc) begin
          if (num_act_reg != '0) begin
            step_load     = 1'b1;
            step_load_val = STEP_W'(num_act_reg) - STEP_W'(1);
          end
        end else begin
          step_en = 1'b1;
        end
      end
      EXEC: begin
        if (step_tc) begin
          step_load     = 1'b1;
          step_load_val = STEP_W'(drain_max - 1);
        end else begin
          step_en = 1'b1;
        end
      end
      DRAIN: begin
        step_en = !step_tc;
      end
      default: begin
        step_en = 1'b0;
      end
    endcase
  end

  // Main sequencer: state, SRAM read port, instruction, status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      mem_cen     <= 1'b1;
      mem_addr    <= '0;
      inst_w      <= INST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      w_base_reg  <= '0;
      a_base_reg  <= '0;
      num_act_reg <= '0;
    end else begin
      // Registered outputs track the state, so the state itself tells us
      // which kind of read is on the bus this cycle; the array sees it next.
      case (state_reg)
        KLOAD:   inst_w <= INST_KLOAD;
        EXEC:    inst_w <= INST_EXEC;
        default: inst_w <= INST_IDLE;
      endcase
      done <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            w_base_reg  <= w_base;
            a_base_reg  <= a_base;
            num_act_reg <= num_act;
            err         <= 1'b0;
            busy        <= 1'b1;
            mem_cen     <= 1'b0;
            mem_addr    <= w_base;
            state_reg   <= KLOAD;
          end
        end
        KLOAD: begin
          if (step_tc) begin
            mem_cen   <= 1'b1;
            state_reg <= KFLUSH;
          end else begin
            mem_addr <= mem_addr + addr_bw'(1);
          end
        end
        KFLUSH: begin
          if (step_tc) begin
            if (num_act_reg == '0) begin
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              mem_cen   <= 1'b0;
              mem_addr  <= a_base_reg;
              state_reg <= EXEC;
            end
          end
        end
        EXEC: begin
          if (step_tc) begin
            mem_cen   <= 1'b1;
            state_reg <= DRAIN;
          end else begin
            mem_addr <= mem_addr + addr_bw'(1);
          end
        end
        DRAIN: begin
          // A completion that lands on the last allowed cycle still wins.
          if (out_cnt == num_act_reg) begin
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (step_tc) begin
            err       <= 1'b1;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          mem_cen   <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Output vector counter: cleared on an accepted start, counts the last
  // column's valid flag in any busy state, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt <= '0;
    end else if ((state_reg == IDLE) && start) begin
      out_cnt <= '0;
    end else if (busy && valid[col-1] && (out_cnt != '1)) begin
      out_cnt <= out_cnt + cnt_bw'(1);
    end
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl with a read scoreboard: expected reads
// are queued at job start and checked as the SRAM port produces them.
module tb_mac_array_ctrl;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] w_base;
  logic [10:0] a_base;
  logic [10:0] num_act;
  logic [7:0]  valid;
  logic        mem_cen;
  logic        mem_wen;
  logic [10:0] mem_addr;
  logic [1:0]  inst_w;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] out_cnt;

  always #5 clk = ~clk;

  mac_array_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .w_base   (w_base),
    .a_base   (a_base),
    .num_act  (num_act),
    .valid    (valid),
    .mem_cen  (mem_cen),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .inst_w   (inst_w),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .out_cnt  (out_cnt)
  );

  typedef struct {
    logic [10:0] addr;
    logic [1:0]  inst;
  } rd_t;

  rd_t  rd_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc = 0;
  int   last_rd_cyc = 0;
  int   done_cyc = 0;
  int   n_done = 0;
  int   n_busy_fall = 0;
  int   n_k_inst = 0;
  int   n_e_inst = 0;
  int   n_e_rd = 0;
  logic [1:0] pend_inst = 2'b00;
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    rd_t  e;
    logic have;
    cyc++;
    if (reset) begin
      pend_inst = 2'b00;
      prev_busy = 1'b0;
    end else begin
      check("inst_w_align", {30'd0, inst_w}, {30'd0, pend_inst});
      if (inst_w == INST_KLOAD) n_k_inst++;
      if (inst_w == INST_EXEC)  n_e_inst++;
      if (mem_cen === 1'b0) begin
        have = (rd_q.size() != 0);
        check("read_expected", {31'd0, have}, 32'd1);
        check("mem_wen_rd", {31'd0, mem_wen}, 32'd1);
        if (have) begin
          e = rd_q.pop_front();
          check("mem_addr", {21'd0, mem_addr}, {21'd0, e.addr});
          pend_inst = e.inst;
          if (e.inst == INST_EXEC) n_e_rd++;
          $display("read cyc=%0d addr=0x%03h exp=0x%03h inst=%0b", cyc, mem_addr, e.addr, e.inst);
        end else begin
          pend_inst = 2'b00;
        end
        last_rd_cyc = cyc;
      end else begin
        pend_inst = 2'b00;
      end
      if (done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
      if (prev_busy && !busy) n_busy_fall++;
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_start(input logic [10:0] w, input logic [10:0] a, input logic [10:0] n);
    rd_t e;
    n_done = 0; n_busy_fall = 0; n_k_inst = 0; n_e_inst = 0; n_e_rd = 0;
    for (int k = 0; k < 8; k++) begin
      e.addr = w + 11'(k); e.inst = INST_KLOAD; rd_q.push_back(e);
    end
    for (int j = 0; j < int'(n); j++) begin
      e.addr = a + 11'(j); e.inst = INST_EXEC; rd_q.push_back(e);
    end
    $display("start w_base=0x%03h a_base=0x%03h num_act=%0d", w, a, n);
    w_base = w; a_base = a; num_act = n; start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble inputs: the job must run from the latched copies.
    w_base = 11'($urandom); a_base = 11'($urandom); num_act = 11'($urandom);
  endtask

  task automatic wait_reads(input int budget);
    int i = 0;
    while (rd_q.size() != 0 && i < budget) begin tick(); i++; end
    check("reads_drained", rd_q.size(), 0);
  endtask

  task automatic pulse_valid(input int n);
    for (int i = 0; i < n; i++) begin
      valid[7] = 1'b1; tick();
      valid[7] = 1'b0; tick();
    end
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (done !== 1'b1 && i < budget) begin tick(); i++; end
    check("done_seen", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cen"},  {31'd0, mem_cen}, 32'd1);
    check({tag, "_wen"},  {31'd0, mem_wen}, 32'd1);
    check({tag, "_addr"}, {21'd0, mem_addr}, 32'd0);
    check({tag, "_inst"}, {30'd0, inst_w}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"},  {31'd0, err}, 32'd0);
    check({tag, "_ocnt"}, {21'd0, out_cnt}, 32'd0);
  endtask

  initial begin
    int i;
    reset = 1'b1; start = 1'b0; w_base = '0; a_base = '0; num_act = '0; valid = '0;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Basic job
    run_start(11'h010, 11'h100, 11'd4);
    wait_reads(100);
    tick();
    pulse_valid(4);
    wait_done(200);
    check("basic_out_cnt", {21'd0, out_cnt}, 32'd4);
    check("basic_err", {31'd0, err}, 32'd0);
    tick(); tick();
    check("basic_k_inst", n_k_inst, 8);
    check("basic_e_inst", n_e_inst, 4);
    check("basic_done_cnt", n_done, 1);
    check("basic_busy_fall", n_busy_fall, 1);
    check("basic_idle_busy", {31'd0, busy}, 32'd0);

    // Zero activations
    run_start(11'h020, 11'h300, 11'd0);
    wait_done(200);
    check("zero_done_lat", done_cyc - last_rd_cyc, 17);
    check("zero_out_cnt", {21'd0, out_cnt}, 32'd0);
    tick(); tick();
    check("zero_k_inst", n_k_inst, 8);
    check("zero_e_inst", n_e_inst, 0);
    check("zero_done_cnt", n_done, 1);

    // Drain timeout
    run_start(11'h040, 11'h080, 11'd3);
    wait_reads(100);
    pulse_valid(2);
    wait_done(300);
    check("tmo_drain_len", done_cyc - last_rd_cyc, 65);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_out_cnt", {21'd0, out_cnt}, 32'd2);
    repeat (5) tick();
    check("tmo_err_sticky", {31'd0, err}, 32'd1);
    check("tmo_out_cnt_hold", {21'd0, out_cnt}, 32'd2);

    // Start while busy and in the DONE cycle
    run_start(11'h050, 11'h150, 11'd4);
    check("start_clears_err", {31'd0, err}, 32'd0);
    check("start_clears_ocnt", {21'd0, out_cnt}, 32'd0);
    i = 0;
    while (n_e_rd < 1 && i < 100) begin tick(); i++; end
    check("busy_exec_reached", n_e_rd, 1);
    w_base = 11'h600; a_base = 11'h700; num_act = 11'd9; start = 1'b1;
    tick();
    start = 1'b0;
    wait_reads(100);
    pulse_valid(4);
    wait_done(200);
    check("busy_out_cnt", {21'd0, out_cnt}, 32'd4);
    w_base = 11'h610; a_base = 11'h710; num_act = 11'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    check("busy_fall_once", n_busy_fall, 1);
    check("busy_done_once", n_done, 1);
    check("busy_no_rerun", {31'd0, busy}, 32'd0);
    check("busy_e_inst", n_e_inst, 4);

    // Reset in the second EXEC cycle
    run_start(11'h060, 11'h200, 11'd4);
    i = 0;
    while (n_e_rd < 2 && i < 100) begin tick(); i++; end
    check("rst_exec_reached", n_e_rd, 2);
    reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    rd_q.delete();
    tick(); tick();
    reset = 1'b0;
    check("rst_no_done", n_done, 0);
    tick();

    // Address wrap, also the post-reset job
    run_start(11'h7FC, 11'h7FE, 11'd4);
    wait_reads(100);
    pulse_valid(4);
    wait_done(200);
    check("wrap_out_cnt", {21'd0, out_cnt}, 32'd4);
    check("wrap_err", {31'd0, err}, 32'd0);
    tick(); tick();
    check("wrap_e_inst", n_e_inst, 4);
    check("wrap_done_cnt", n_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
